regfile_multiport_bt: RTL and testbench

- Parametrised successor to the CPU datapath register file: DEPTH x WIDTH registers, three combinational read ports, one write port and a dedicated PC register.
- Adds PC auto-increment and a block-transfer sequencer (load-multiple style) that writes a register list one word per handshake.
- Sits between the control unit, the ALU/barrel-shifter operand buses and the memory data return path.

---
 rtl/regfile_multiport_bt.sv | 183 ++++++++++++++++++
 tb/tb_regfile_multiport_bt.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_multiport_bt.sv
// regfile_multiport_bt: DEPTH x WIDTH register file with three combinational
// read ports, one write port, a PC register with auto-increment and a
// load-multiple style block-transfer sequencer.
// Optional macro WRITE_BYPASS_EN: forwards same-cycle write data to the read
// ports (sequencer write first, then wr_en). Without it reads see stored state only.
module regfile_multiport_bt #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 16,
    parameter int AW      = $clog2(DEPTH),
    parameter int PC_STEP = 4
) (
    input  logic             Clk,
    input  logic             RESET,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    wr_sel,
    input  logic             wr_en,
    input  logic [AW-1:0]    rn_sel_ir,
    input  logic [AW-1:0]    rn_sel_cu,
    input  logic             ir_cu,
    input  logic [AW-1:0]    rm_sel,
    input  logic [AW-1:0]    rs_sel,
    output logic [WIDTH-1:0] rn,
    output logic [WIDTH-1:0] rm,
    output logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] pc_in,
    input  logic             pc_load,
    input  logic             pc_inc,
    output logic [WIDTH-1:0] pc_out,
    input  logic             bt_start,
    input  logic [DEPTH-1:0] bt_list,
    input  logic [WIDTH-1:0] bt_data,
    input  logic             bt_valid,
    output logic             bt_ready,
    output logic [AW-1:0]    bt_idx,
    output logic             bt_busy,
    output logic             bt_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } bt_state_t;

    logic [WIDTH-1:0] r_regs [DEPTH];
    logic [WIDTH-1:0] r_pc;
    bt_state_t        r_state;
    bt_state_t        w_state_nxt;
    logic [DEPTH-1:0] r_pending;
    logic [DEPTH-1:0] w_pending_nxt;
    logic [DEPTH-1:0] w_clr_mask;
    logic [AW-1:0]    w_bt_idx;
    logic             w_seq_we;
    logic [AW-1:0]    w_rn_sel;

    // Index of the lowest set bit of a register mask (0 when the mask is empty).
    function automatic logic [AW-1:0] f_lowest_set(input logic [DEPTH-1:0] mask);
        logic [AW-1:0] idx;
        idx = {AW{1'b0}};
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = AW'(i);
            end
        end
        return idx;
    endfunction

    // Read-port data for one index, with optional same-cycle write forwarding.
    function automatic logic [WIDTH-1:0] f_read(input logic [AW-1:0] sel);
        logic [WIDTH-1:0] val;
        val = r_regs[sel];
`ifdef WRITE_BYPASS_EN
        if (w_seq_we && (sel == w_bt_idx)) begin
            val = bt_data;
        end else if (wr_en && (sel == wr_sel)) begin
            val = wr_data;
        end else begin
            val = r_regs[sel];
        end
`endif
        return val;
    endfunction

    assign w_bt_idx   = (r_state == ST_XFER) ? f_lowest_set(r_pending) : {AW{1'b0}};
    assign w_seq_we   = (r_state == ST_XFER) && bt_valid;
    assign w_clr_mask = {{(DEPTH-1){1'b0}}, 1'b1} << w_bt_idx;
    assign w_rn_sel   = ir_cu ? rn_sel_cu : rn_sel_ir;

    assign rn = f_read(w_rn_sel);
    assign rm = f_read(rm_sel);
    assign rs = f_read(rs_sel);

    assign pc_out   = r_pc;
    assign bt_idx   = w_bt_idx;
    assign bt_ready = (r_state == ST_XFER);
    assign bt_busy  = (r_state == ST_XFER) || (r_state == ST_DONE);
    assign bt_done  = (r_state == ST_DONE);

    // Register array update: the sequencer write wins over wr_en on the same index.
    always_ff @(posedge Clk or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= {WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_seq_we && (w_bt_idx == AW'(i))) begin
                    r_regs[i] <= bt_data;
                end else if (wr_en && (wr_sel == AW'(i))) begin
                    r_regs[i] <= wr_data;
                end else begin
                    r_regs[i] <= r_regs[i];
                end
            end
        end
    end

    // PC register: load beats increment; increment wraps modulo 2^WIDTH.
    always_ff @(posedge Clk or posedge RESET) begin
        if (RESET) begin
            r_pc <= {WIDTH{1'b0}};
        end else if (pc_load) begin
            r_pc <= pc_in;
        end else if (pc_inc) begin
            r_pc <= r_pc + WIDTH'(PC_STEP);
        end else begin
            r_pc <= r_pc;
        end
    end

    // Sequencer state and pending-mask registers.
    always_ff @(posedge Clk or posedge RESET) begin
        if (RESET) begin
            r_state   <= ST_IDLE;
            r_pending <= {DEPTH{1'b0}};
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
        end
    end

    // Sequencer next-state: latch mask on start, retire one register per accepted word.
    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        case (r_state)
            ST_IDLE: begin
                if (bt_start) begin
                    if (bt_list != {DEPTH{1'b0}}) begin
                        w_state_nxt   = ST_XFER;
                        w_pending_nxt = bt_list;
                    end else begin
                        w_state_nxt   = ST_DONE;
                        w_pending_nxt = {DEPTH{1'b0}};
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_XFER: begin
                if (w_seq_we) begin
                    w_pending_nxt = r_pending & ~w_clr_mask;
                    if ((r_pending & ~w_clr_mask) == {DEPTH{1'b0}}) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_XFER;
                    end
                end else begin
                    w_state_nxt = ST_XFER;
                end
            end
            ST_DONE: begin
                w_state_nxt   = ST_IDLE;
                w_pending_nxt = {DEPTH{1'b0}};
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_pending_nxt = {DEPTH{1'b0}};
            end
        endcase
    end

endmodule

// File: tb/tb_regfile_multiport_bt.sv
// Directed testbench for regfile_multiport_bt (default parameters).
// Inputs change on the falling clock edge; outputs are sampled shortly after.
module tb_regfile_multiport_bt;

    logic        Clk;
    logic        RESET;
    logic [31:0] wr_data;
    logic [3:0]  wr_sel;
    logic        wr_en;
    logic [3:0]  rn_sel_ir;
    logic [3:0]  rn_sel_cu;
    logic        ir_cu;
    logic [3:0]  rm_sel;
    logic [3:0]  rs_sel;
    logic [31:0] rn;
    logic [31:0] rm;
    logic [31:0] rs;
    logic [31:0] pc_in;
    logic        pc_load;
    logic        pc_inc;
    logic [31:0] pc_out;
    logic        bt_start;
    logic [15:0] bt_list;
    logic [31:0] bt_data;
    logic        bt_valid;
    logic        bt_ready;
    logic [3:0]  bt_idx;
    logic        bt_busy;
    logic        bt_done;

    int n_vec;
    int n_err;
    int n_done_pulses;

    regfile_multiport_bt dut (
        .Clk(Clk), .RESET(RESET),
        .wr_data(wr_data), .wr_sel(wr_sel), .wr_en(wr_en),
        .rn_sel_ir(rn_sel_ir), .rn_sel_cu(rn_sel_cu), .ir_cu(ir_cu),
        .rm_sel(rm_sel), .rs_sel(rs_sel),
        .rn(rn), .rm(rm), .rs(rs),
        .pc_in(pc_in), .pc_load(pc_load), .pc_inc(pc_inc), .pc_out(pc_out),
        .bt_start(bt_start), .bt_list(bt_list), .bt_data(bt_data),
        .bt_valid(bt_valid), .bt_ready(bt_ready), .bt_idx(bt_idx),
        .bt_busy(bt_busy), .bt_done(bt_done)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Count bt_done pulses seen at active edges.
    always @(posedge Clk) begin
        if (bt_done) n_done_pulses <= n_done_pulses + 1;
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic read_rm(input logic [3:0] idx, input string tag, input logic [31:0] exp);
        rm_sel = idx;
        #1;
        check_value(tag, rm, exp);
    endtask

    initial begin
        n_vec = 0; n_err = 0; n_done_pulses = 0;
        RESET = 1'b1;
        wr_data = 32'h0; wr_sel = 4'd0; wr_en = 1'b0;
        rn_sel_ir = 4'd0; rn_sel_cu = 4'd0; ir_cu = 1'b0;
        rm_sel = 4'd0; rs_sel = 4'd0;
        pc_in = 32'h0; pc_load = 1'b0; pc_inc = 1'b0;
        bt_start = 1'b0; bt_list = 16'h0; bt_data = 32'h0; bt_valid = 1'b0;
        #12;
        RESET = 1'b0;
        #1;
        check_value("rst_rn", rn, 32'h0);
        check_value("rst_pc", pc_out, 32'h0);
        check_value("rst_busy", {31'd0, bt_busy}, 32'h0);
        check_value("rst_ready", {31'd0, bt_ready}, 32'h0);
        check_value("rst_done", {31'd0, bt_done}, 32'h0);
        check_value("rst_idx", {28'd0, bt_idx}, 32'h0);

        // Reset mid-operation
        @(negedge Clk);
        wr_en = 1'b1; wr_sel = 4'd3; wr_data = 32'hDEADBEEF;
        pc_load = 1'b1; pc_in = 32'h100;
        @(negedge Clk);
        wr_en = 1'b0; pc_load = 1'b0;
        ir_cu = 1'b1; rn_sel_cu = 4'd3; rs_sel = 4'd3;
        bt_start = 1'b1; bt_list = 16'h0002;
        read_rm(4'd3, "pre_rst_r3", 32'hDEADBEEF);
        check_value("pre_rst_pc", pc_out, 32'h100);
        @(negedge Clk);
        bt_start = 1'b0;
        #1;
        check_value("pre_rst_busy", {31'd0, bt_busy}, 32'h1);
        #1;
        RESET = 1'b1;
        #1;
        check_value("arst_rn", rn, 32'h0);
        check_value("arst_rm", rm, 32'h0);
        check_value("arst_rs", rs, 32'h0);
        check_value("arst_pc", pc_out, 32'h0);
        check_value("arst_busy", {31'd0, bt_busy}, 32'h0);
        @(negedge Clk);
        RESET = 1'b0;
        ir_cu = 1'b0;

        // Fill Ri = i * 0x11111111
        for (int i = 0; i < 16; i++) begin
            @(negedge Clk);
            wr_en = 1'b1; wr_sel = 4'(i); wr_data = 32'(i) * 32'h11111111;
        end
        @(negedge Clk);
        wr_en = 1'b0;
        rm_sel = 4'd5; rs_sel = 4'd15; ir_cu = 1'b1; rn_sel_cu = 4'd7; rn_sel_ir = 4'd2;
        #1;
        check_value("rd_rm5", rm, 32'h55555555);
        check_value("rd_rs15", rs, 32'hFFFFFFFF);
        check_value("rd_rn_cu7", rn, 32'h77777777);
        ir_cu = 1'b0;
        #1;
        check_value("rd_rn_ir2", rn, 32'h22222222);

        // Same-cycle read of a register being written
        @(negedge Clk);
        rm_sel = 4'd6; wr_en = 1'b1; wr_sel = 4'd6; wr_data = 32'h1234;
        #1;
`ifdef WRITE_BYPASS_EN
        check_value("byp_same", rm, 32'h1234);
`else
        check_value("byp_same", rm, 32'h66666666);
`endif
        @(negedge Clk);
        wr_en = 1'b0;
        #1;
        check_value("byp_next", rm, 32'h1234);

        // PC load, wrap, load-over-increment
        pc_load = 1'b1; pc_in = 32'hFFFFFFFC;
        @(negedge Clk);
        pc_load = 1'b0; pc_inc = 1'b1;
        #1;
        check_value("pc_load", pc_out, 32'hFFFFFFFC);
        @(negedge Clk);
        pc_inc = 1'b0;
        #1;
        check_value("pc_wrap", pc_out, 32'h0);
        pc_load = 1'b1; pc_inc = 1'b1; pc_in = 32'h40;
        @(negedge Clk);
        pc_load = 1'b0;
        #1;
        check_value("pc_ld_pri", pc_out, 32'h40);
        @(negedge Clk);
        pc_inc = 1'b0;
        #1;
        check_value("pc_inc", pc_out, 32'h44);
        check_value("pc_hold_pre", {31'd0, bt_done}, 32'h0);

        // Block transfer 0x8025 with a two-cycle stall before the third word
        n_done_pulses = 0;
        bt_start = 1'b1; bt_list = 16'h8025;
        @(negedge Clk);
        bt_start = 1'b0;
        #1;
        check_value("bt_busy", {31'd0, bt_busy}, 32'h1);
        check_value("bt_ready", {31'd0, bt_ready}, 32'h1);
        check_value("bt_idx0", {28'd0, bt_idx}, 32'd0);
        bt_valid = 1'b1; bt_data = 32'hA;
        @(negedge Clk);
        #1;
        check_value("bt_idx1", {28'd0, bt_idx}, 32'd2);
        bt_data = 32'hB;
        @(negedge Clk);
        #1;
        check_value("bt_idx2", {28'd0, bt_idx}, 32'd5);
        bt_valid = 1'b0; bt_data = 32'hEE;
        @(negedge Clk);
        @(negedge Clk);
        #1;
        check_value("bt_stall_idx", {28'd0, bt_idx}, 32'd5);
        check_value("bt_stall_rdy", {31'd0, bt_ready}, 32'h1);
        check_value("bt_stall_done", {31'd0, bt_done}, 32'h0);
        bt_valid = 1'b1; bt_data = 32'hC;
        @(negedge Clk);
        #1;
        check_value("bt_idx3", {28'd0, bt_idx}, 32'd15);
        bt_data = 32'hD;
        @(negedge Clk);
        bt_valid = 1'b0;
        #1;
        check_value("bt_done_hi", {31'd0, bt_done}, 32'h1);
        check_value("bt_done_busy", {31'd0, bt_busy}, 32'h1);
        check_value("bt_done_rdy", {31'd0, bt_ready}, 32'h0);
        @(negedge Clk);
        #1;
        check_value("bt_done_lo", {31'd0, bt_done}, 32'h0);
        check_value("bt_idle_busy", {31'd0, bt_busy}, 32'h0);
        check_value("bt_pulses", 32'(n_done_pulses), 32'd1);
        read_rm(4'd0, "bt_r0", 32'hA);
        read_rm(4'd2, "bt_r2", 32'hB);
        read_rm(4'd5, "bt_r5", 32'hC);
        @(negedge Clk);
        read_rm(4'd15, "bt_r15", 32'hD);
        read_rm(4'd1, "bt_r1_kept", 32'h11111111);

        // Empty list: done next cycle, no writes
        bt_start = 1'b1; bt_list = 16'h0; bt_valid = 1'b1; bt_data = 32'hBAD;
        @(negedge Clk);
        bt_start = 1'b0; bt_valid = 1'b0;
        #1;
        check_value("empty_done", {31'd0, bt_done}, 32'h1);
        check_value("empty_rdy", {31'd0, bt_ready}, 32'h0);
        @(negedge Clk);
        #1;
        check_value("empty_done_lo", {31'd0, bt_done}, 32'h0);
        read_rm(4'd0, "empty_r0", 32'hA);

        // Collision on the same index: sequencer wins
        bt_start = 1'b1; bt_list = 16'h0004;
        @(negedge Clk);
        bt_start = 1'b0;
        #1;
        check_value("col_idx", {28'd0, bt_idx}, 32'd2);
        bt_valid = 1'b1; bt_data = 32'h77; wr_en = 1'b1; wr_sel = 4'd2; wr_data = 32'h99;
        @(negedge Clk);
        bt_valid = 1'b0; wr_en = 1'b0;
        read_rm(4'd2, "col_same_r2", 32'h77);
        @(negedge Clk);

        // Collision on different indices: both writes land
        bt_start = 1'b1; bt_list = 16'h0004;
        @(negedge Clk);
        bt_start = 1'b0;
        bt_valid = 1'b1; bt_data = 32'h55; wr_en = 1'b1; wr_sel = 4'd4; wr_data = 32'h99;
        @(negedge Clk);
        bt_valid = 1'b0; wr_en = 1'b0;
        read_rm(4'd4, "col_diff_r4", 32'h99);
        read_rm(4'd2, "col_diff_r2", 32'h55);
        @(negedge Clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
